// File: rtl/action_selector.sv
// Picks an action for one state: greedy argmax over the state's Q-values, or epsilon-greedy exploration.
// Latency: start accepted on E0, done pulses on E(N_ACTIONS+1), so 5 edges for 4 actions.
// Backpressure: none; start is ignored while busy and accepted again in the DONE cycle.
module action_selector #(
  parameter  int DATA_W    = 16,
  parameter  int ADDR_W    = 6,
  parameter  int N_ACTIONS = 4,
  localparam int A_W       = $clog2(N_ACTIONS),
  localparam int S_W       = ADDR_W - A_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [S_W-1:0]           state,
  input  logic [7:0]               epsilon,
  output logic                     busy,
  output logic                     done,
  output logic [A_W-1:0]           action,
  output logic signed [DATA_W-1:0] q_max,
  output logic                     explored,
  output logic                     ram_en,
  output logic [ADDR_W-1:0]        ram_rd_addr,
  input  logic signed [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} fsm_t;

  fsm_t                     r_fsm;
  logic [7:0]               r_lfsr;
  logic [7:0]               r_snap;
  logic [7:0]               r_eps;
  logic                     r_rd_vld;
  logic [A_W-1:0]           r_rd_idx;
  logic signed [DATA_W-1:0] r_max;
  logic [A_W-1:0]           r_arg;

  logic                     w_lfsr_fb;
  logic                     w_take;
  logic signed [DATA_W-1:0] w_max;
  logic [A_W-1:0]           w_arg;
  logic                     w_last_addr;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // First word of a scan loads unconditionally; later words replace only on strictly
  // greater, so ties keep the lowest action index.
  assign w_take = r_rd_vld && ((r_rd_idx == '0) || (ram_data_out > r_max));
  assign w_max  = w_take ? ram_data_out : r_max;
  assign w_arg  = w_take ? r_rd_idx : r_arg;

  assign w_last_addr = (ram_rd_addr[A_W-1:0] == A_W'(N_ACTIONS - 1));

  // Free-running LFSR, advances every cycle regardless of FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  // Compare pipeline: RAM data arrives the cycle after ram_en, tagged with its action index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
      r_max    <= '0;
      r_arg    <= '0;
    end else begin
      r_rd_vld <= ram_en;
      r_rd_idx <= ram_rd_addr[A_W-1:0];
      r_max    <= w_max;
      r_arg    <= w_arg;
    end
  end

  // Control FSM with registered outputs; DRAIN folds in the last word while publishing results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_snap      <= '0;
      r_eps       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      action      <= '0;
      q_max       <= '0;
      explored    <= 1'b0;
      ram_en      <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_snap      <= r_lfsr;
            r_eps       <= epsilon;
            busy        <= 1'b1;
            ram_en      <= 1'b1;
            ram_rd_addr <= {state, {A_W{1'b0}}};
            r_fsm       <= S_SCAN;
          end else begin
            r_fsm <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (w_last_addr) begin
            ram_en      <= 1'b0;
            ram_rd_addr <= '0;
            r_fsm       <= S_DRAIN;
          end else begin
            ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          q_max <= w_max;
          if (r_snap < r_eps) begin
            action   <= r_snap[A_W-1:0];
            explored <= 1'b1;
          end else begin
            action   <= w_arg;
            explored <= 1'b0;
          end
          r_fsm <= S_DONE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// Scoreboarded bench for action_selector: a behavioural model predicts each selection
// and its read addresses at the accepting edge; a negedge monitor checks DUT outputs.
module tb_action_selector;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int N      = 4;
  localparam int A_W    = 2;
  localparam int S_W    = 4;
  localparam int LAT    = N + 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [S_W-1:0]           state = '0;
  logic [7:0]               epsilon = '0;
  logic                     busy, done, explored, ram_en;
  logic [A_W-1:0]           action;
  logic signed [DATA_W-1:0] q_max;
  logic [ADDR_W-1:0]        ram_rd_addr;
  logic signed [DATA_W-1:0] ram_data_out = '0;

  logic signed [DATA_W-1:0] mem [0:63];

  typedef struct {
    logic [A_W-1:0]           act;
    logic signed [DATA_W-1:0] q;
    logic                     exp;
    int                       cyc;
  } exp_t;

  exp_t              sb_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  exp_t              mon_e;
  int n_vec = 0;
  int n_err = 0;
  int m_cyc;
  int m_next_ok = 0;

  action_selector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_ACTIONS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .epsilon(epsilon),
    .busy(busy), .done(done), .action(action), .q_max(q_max), .explored(explored),
    .ram_en(ram_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data is valid the cycle after the enabled address
  always @(posedge clk) if (ram_en) ram_data_out <= mem[ram_rd_addr];

  // Edges elapsed since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) m_cyc <= 0;
    else     m_cyc <= m_cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // LFSR value after n steps from the reset seed
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic exp_t model(input int s, input logic [7:0] e, input int k);
    exp_t r;
    logic [7:0] snap;
    int best;
    best = 0;
    for (int a = 1; a < N; a++)
      if (mem[s*N + a] > mem[s*N + best]) best = a;
    snap  = lfsr_at(k);
    r.q   = mem[s*N + best];
    r.cyc = k + LAT;
    if (snap < e) begin
      r.act = A_W'(snap % N);
      r.exp = 1'b1;
    end else begin
      r.act = A_W'(best);
      r.exp = 1'b0;
    end
    return r;
  endfunction

  // Drive one cycle of inputs; predict acceptance from the DUT's documented timing
  task automatic cyc(input bit st, input int s, input logic [7:0] e);
    @(negedge clk);
    start   = st;
    state   = S_W'(s);
    epsilon = e;
    if (st && m_cyc >= m_next_ok) begin
      sb_q.push_back(model(s, e, m_cyc));
      for (int a = 0; a < N; a++) addr_q.push_back(ADDR_W'(s*N + a));
      m_next_ok = m_cyc + LAT;
    end
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || m_cyc < m_next_ok) && guard < 30) begin
      cyc(1'b0, 0, 8'd0);
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done, required %0d pending results", sb_q.size());
      sb_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_explored"}, explored, 0);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_action"}, action, 0);
    check({tag, "_q_max"}, q_max, 0);
    check({tag, "_rd_addr"}, ram_rd_addr, 0);
  endtask

  // Monitor: compare against the scoreboard whenever the DUT presents a result or a read
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1, required no pending request (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("action", action, mon_e.act);
          check("q_max", q_max, mon_e.q);
          check("explored", explored, mon_e.exp);
          check("done_edge", m_cyc, mon_e.cyc);
          check("busy_in_done", busy, 0);
        end
      end
      if (ram_en) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: got addr %0d, required no read (t=%0t)", ram_rd_addr, $time);
        end else begin
          check("rd_addr", ram_rd_addr, addr_q.pop_front());
        end
      end else begin
        check("rd_addr_idle", ram_rd_addr, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[12] = 16'sd5;   mem[13] = -16'sd2;  mem[14] = 16'sd40;  mem[15] = 16'sd40;
    mem[0]  = -16'sd100; mem[1] = -16'sd7;  mem[2] = -16'sd300; mem[3] = -16'sd8;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;

    // First start after reset: snapshot is the seed, epsilon FF forces exploration
    cyc(1'b1, 3, 8'hFF);
    wait_idle();

    // Greedy with a tie, then all-negative entries
    cyc(1'b1, 3, 8'h00);
    wait_idle();
    cyc(1'b1, 0, 8'h00);
    wait_idle();

    // start re-pulsed mid-scan with a different state is ignored
    cyc(1'b1, 3, 8'h00);
    cyc(1'b0, 0, 8'h00);
    cyc(1'b1, 7, 8'hFF);
    cyc(1'b0, 0, 8'h00);
    wait_idle();

    // start held through the DONE cycle: second scan starts right away
    for (int i = 0; i < LAT + 1; i++) cyc(1'b1, 0, 8'h00);
    cyc(1'b0, 0, 8'h00);
    wait_idle();

    // Reset during the third SCAN cycle aborts the request with no done
    cyc(1'b1, 3, 8'h00);
    cyc(1'b0, 0, 8'h00);
    cyc(1'b0, 0, 8'h00);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midscan_rst");
    sb_q.delete();
    addr_q.delete();
    m_next_ok = 0;
    start = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    cyc(1'b1, 3, 8'h00);
    wait_idle();

    // Randomised selections: wide-range values, then narrow values for frequent ties
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 64; i++)
        mem[i] = (round == 0) ? DATA_W'($urandom) : DATA_W'($signed($urandom_range(0, 6)) - 3);
      for (int c = 0; c < 200; c++) begin
        int sel;
        logic [7:0] e;
        sel = $urandom_range(0, 2);
        e = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15), e);
      end
      cyc(1'b0, 0, 8'h00);
      wait_idle();
    end

    check("sb_empty", sb_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
